// File: rtl/mfcc_framer.sv
// Overlapping-window framer for an MFCC front end: buffers 16-bit PCM samples and
// replays each N-sample window, oldest first, as IEEE-754 single-precision floats.
module mfcc_framer #(
    parameter int N   = 256,
    parameter int HOP = 128
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] frame_cnt
);

    localparam int DEPTH = 2 * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(N);

    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] N_P      = PW'(N);
    localparam logic [PW-1:0] HOP_P    = PW'(HOP);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_SEND
    } state_e;

    // rst_n is an active-high synchronous reset despite its name.
    logic in_reset;
    assign in_reset = rst_n;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] base_q, base_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   rd_data_q;

    logic [PW-1:0] occupancy;
    logic [AW-1:0] rd_addr;
    logic          accept;

    // Exact int16 -> float32: a 16-bit magnitude always fits in the 24-bit significand.
    function automatic logic [31:0] to_float(input logic [15:0] x);
        logic [16:0] mag;
        logic [4:0]  msb;
        logic [22:0] mant;
        mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
        msb = '0;
        for (int i = 0; i < 17; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        mant = 23'(24'(mag) << (5'd23 - msb));
        if (x == 16'd0) return 32'd0;
        return {x[15], 8'd127 + 8'(msb), mant};
    endfunction

    assign occupancy = wr_ptr_q - base_q;
    assign rd_addr   = base_q[AW-1:0] + AW'(rd_idx_q);
    assign s_ready   = !in_reset && en && !clr && (occupancy < DEPTH_P);
    assign accept    = s_valid && s_ready;

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;

    // NOTE: the sample buffer has no reset; the pointers alone define which entries are live.
    always_ff @(posedge hclk) begin
        if (accept) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end

    always_ff @(posedge hclk) begin
        if (state_q == S_FETCH) rd_data_q <= mem_q[rd_addr];
    end

    // NOTE: every _d takes its current value first, so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        rd_idx_d    = rd_idx_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;

        if (accept) wr_ptr_d = wr_ptr_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (en && occupancy >= N_P) begin
                    state_d  = S_FETCH;
                    rd_idx_d = '0;
                end
            end
            S_FETCH: state_d = S_CONV;
            S_CONV: begin
                m_data_d  = to_float(rd_data_q);
                m_last_d  = (rd_idx_q == LAST_IDX);
                m_valid_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (rd_idx_q == LAST_IDX) begin
                        base_d      = base_q + HOP_P;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush abandons any frame in flight; a frame completed on this edge still counts.
        if (clr) begin
            state_d   = S_IDLE;
            wr_ptr_d  = '0;
            base_d    = '0;
            rd_idx_d  = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // NOTE: flops take non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge hclk) begin
        if (in_reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            rd_idx_q    <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            rd_idx_q    <= rd_idx_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_mfcc_framer.sv
// Scoreboard bench for mfcc_framer: accepted samples feed a framing model whose
// float outputs are queued and compared against every output handshake.
`timescale 1ns/1ps
module tb_mfcc_framer;

    localparam int N   = 256;
    localparam int HOP = 128;

    logic        hclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic [15:0] frame_cnt;

    always #5 hclk = ~hclk;

    mfcc_framer #(.N(N), .HOP(HOP)) dut (
        .hclk      (hclk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] acc_q[$];
    int          frames_pushed = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          outs_seen = 0;
    int          cyc = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    // Arithmetic reference: find the power of two below |x| by search, scale the remainder.
    function automatic logic [31:0] model_float(input logic [15:0] v);
        longint x, m, p;
        int     e;
        x = longint'($signed(v));
        if (x == 0) return 32'h0;
        m = (x < 0) ? -x : x;
        p = 1;
        e = 0;
        while (p * 2 <= m) begin
            p = p * 2;
            e++;
        end
        return {(x < 0) ? 1'b1 : 1'b0, 8'(127 + e), 23'((m - p) << (23 - e))};
    endfunction

    task automatic model_accept(input logic [15:0] v);
        acc_q.push_back(v);
        if (acc_q.size() >= N + frames_pushed * HOP) begin
            for (int i = 0; i < N; i++)
                exp_q.push_back('{data: model_float(acc_q[frames_pushed * HOP + i]), last: (i == N - 1)});
            frames_pushed++;
        end
    endtask

    task automatic model_flush();
        acc_q.delete();
        exp_q.delete();
        frames_pushed = 0;
    endtask

    // Output monitor: samples at negedge+2, after the stimulus tasks have driven.
    bit          stall_seen = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;
    int          last_hs = -1;
    exp_t        mon_e;

    always begin
        @(negedge hclk);
        #2;
        if (rst_n !== 1'b0 || clr !== 1'b0) begin
            stall_seen = 1'b0;
            last_hs    = -1;
        end else begin
            if (stall_seen) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last)
                    $display("FAIL hold_stable: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             m_valid, m_data, m_last, stall_data, stall_last);
                else n_pass++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                outs_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_out: got d=%h l=%b, need no output", m_data, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_data !== mon_e.data || m_last !== mon_e.last)
                        $display("FAIL out_sample: got d=%h l=%b, need d=%h l=%b",
                                 m_data, m_last, mon_e.data, mon_e.last);
                    else n_pass++;
                end
                if (last_hs >= 0) begin
                    n_checks++;
                    if (cyc - last_hs != 3)
                        $display("FAIL out_rate: got %0d cycles between outputs, need 3", cyc - last_hs);
                    else n_pass++;
                end
                last_hs = (m_last === 1'b1) ? -1 : cyc;
            end
            stall_seen = (m_valid === 1'b1 && m_ready !== 1'b1);
            stall_data = m_data;
            stall_last = m_last;
        end
    end

    task automatic feed(input logic [15:0] vals[$], input bit drop_en);
        int idx = 0;
        int cycles = 0;
        while (idx < vals.size() && cycles < 4000) begin
            @(negedge hclk);
            s_valid = 1'b1;
            s_data  = vals[idx];
            #1;
            if (s_ready === 1'b1) begin
                model_accept(vals[idx]);
                idx++;
            end
            cycles++;
        end
        @(negedge hclk);
        s_valid = 1'b0;
        if (drop_en) en = 1'b0;
        n_checks++;
        if (idx != vals.size()) $display("FAIL feed_accept: accepted %0d, need %0d", idx, vals.size());
        else n_pass++;
    endtask

    task automatic wait_drain(input string tag);
        int cycles = 0;
        while (exp_q.size() != 0 && cycles < 4000) begin
            @(negedge hclk);
            #3;
            cycles++;
        end
        @(negedge hclk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d outputs missing, need 0", tag, exp_q.size());
        else n_pass++;
    endtask

    task automatic do_clr();
        @(negedge hclk);
        clr = 1'b1;
        model_flush();
        @(negedge hclk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        bit saw_valid = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        #1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b, need 0", s_ready); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b, need 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== 32'h0) $display("FAIL rst_m_data: got %h, need 0", m_data); else n_pass++;
        n_checks++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b, need 0", m_last); else n_pass++;
        n_checks++; if (frame_cnt !== 16'h0) $display("FAIL rst_frame_cnt: got %h, need 0", frame_cnt); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL post_rst_s_ready: got %b, need 1", s_ready); else n_pass++;
        repeat (10) begin
            @(negedge hclk);
            #1;
            if (m_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid) $display("FAIL idle_m_valid: got 1, need 0"); else n_pass++;
    endtask

    task automatic test_ramp_frame();
        logic [15:0] v[$];
        for (int i = 0; i < 256; i++) v.push_back(16'(i));
        feed(v, 1'b0);
        wait_drain("frame0");
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL frame0_cnt: got %0d, need 1", frame_cnt); else n_pass++;
    endtask

    task automatic test_hop_frame();
        logic [15:0] v[$];
        for (int i = 256; i < 384; i++) v.push_back(16'(i));
        feed(v, 1'b0);
        wait_drain("frame1");
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL frame1_cnt: got %0d, need 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_corners();
        logic [15:0] v[$];
        logic [15:0] corner_in  [5] = '{16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0100};
        logic [31:0] corner_exp [5] = '{32'hC7000000, 32'hBF800000, 32'h3F800000, 32'h46FFFE00, 32'h43800000};
        logic [15:0] fc0;
        fc0 = frame_cnt;
        do_clr();
        n_checks++; if (frame_cnt !== fc0) $display("FAIL clr_frame_cnt: got %0d, need %0d", frame_cnt, fc0); else n_pass++;
        for (int i = 0; i < 5; i++) v.push_back(corner_in[i]);
        for (int i = 5; i < 256; i++) v.push_back(16'(i * 97 - 12000));
        feed(v, 1'b0);
        for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
        for (int i = 4; i >= 0; i--) exp_q.push_front('{data: corner_exp[i], last: 1'b0});
        wait_drain("corners");
        n_checks++; if (frame_cnt !== fc0 + 16'd1) $display("FAIL corners_cnt: got %0d, need %0d", frame_cnt, fc0 + 16'd1); else n_pass++;
    endtask

    task automatic test_backpressure();
        int          taken = 0;
        int          cycles = 0;
        logic [15:0] fc0;
        fc0 = frame_cnt;
        do_clr();
        m_ready = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge hclk);
            s_valid = 1'b1;
            s_data  = 16'(taken * 131 - 30000);
            #1;
            if (s_ready === 1'b1) begin
                model_accept(s_data);
                taken++;
            end
        end
        @(negedge hclk);
        s_valid = 1'b0;
        #1;
        n_checks++; if (taken != 512) $display("FAIL full_accept: got %0d, need 512", taken); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL full_s_ready: got %b, need 0", s_ready); else n_pass++;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp_q[0].data)
            $display("FAIL stall_head: got v=%b d=%h, need v=1 d=%h", m_valid, m_data, exp_q[0].data);
        else n_pass++;
        m_ready = 1'b1;
        while (s_ready !== 1'b1 && cycles < 2000) begin
            @(negedge hclk);
            #1;
            cycles++;
        end
        n_checks++;
        if (s_ready !== 1'b1 || frame_cnt !== fc0 + 16'd1)
            $display("FAIL ready_return: got s_ready=%b cnt=%0d, need s_ready=1 cnt=%0d", s_ready, frame_cnt, fc0 + 16'd1);
        else n_pass++;
        wait_drain("backpressure");
        n_checks++; if (frame_cnt !== fc0 + 16'd3) $display("FAIL bp_cnt: got %0d, need %0d", frame_cnt, fc0 + 16'd3); else n_pass++;
    endtask

    task automatic test_enable();
        logic [15:0] v[$];
        logic [15:0] fc0;
        bit          saw_ready = 1'b0;
        bit          saw_valid = 1'b0;
        fc0 = frame_cnt;
        for (int i = 0; i < 128; i++) v.push_back(16'(5000 - 77 * i));
        feed(v, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            s_valid = 1'b1;
            #1;
            if (s_ready !== 1'b0) saw_ready = 1'b1;
            if (m_valid !== 1'b0) saw_valid = 1'b1;
        end
        s_valid = 1'b0;
        n_checks++; if (saw_ready) $display("FAIL en_off_s_ready: got 1, need 0"); else n_pass++;
        n_checks++; if (saw_valid) $display("FAIL en_off_start: got m_valid 1, need 0"); else n_pass++;
        en = 1'b1;
        wait_drain("enable");
        n_checks++; if (frame_cnt !== fc0 + 16'd1) $display("FAIL en_cnt: got %0d, need %0d", frame_cnt, fc0 + 16'd1); else n_pass++;
    endtask

    task automatic test_abort(input bit use_rst);
        logic [15:0] v[$];
        logic [15:0] fc0;
        int          target;
        int          cycles = 0;
        bit          hit = 1'b0;
        do_clr();
        fc0 = frame_cnt;
        m_ready = 1'b1;
        for (int i = 0; i < 256; i++) v.push_back(16'(1000 + 3 * i));
        feed(v, 1'b0);
        target = outs_seen + 100;
        while (!hit && cycles < 2000) begin
            @(negedge hclk);
            #1;
            if (outs_seen >= target && m_valid === 1'b1) hit = 1'b1;
            cycles++;
        end
        n_checks++; if (!hit) $display("FAIL abort_reach: got %0d outputs, need %0d", outs_seen, target); else n_pass++;
        m_ready = 1'b0;
        if (use_rst) rst_n = 1'b1;
        else clr = 1'b1;
        model_flush();
        @(negedge hclk);
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL abort_m_valid: got %b, need 0", m_valid); else n_pass++;
        n_checks++; if (m_last !== 1'b0) $display("FAIL abort_m_last: got %b, need 0", m_last); else n_pass++;
        n_checks++;
        if (frame_cnt !== (use_rst ? 16'd0 : fc0))
            $display("FAIL abort_cnt: got %0d, need %0d", frame_cnt, use_rst ? 16'd0 : fc0);
        else n_pass++;
        rst_n   = 1'b0;
        clr     = 1'b0;
        m_ready = 1'b1;
        v.delete();
        for (int i = 0; i < 256; i++) v.push_back(16'(-500 + 7 * i));
        feed(v, 1'b0);
        wait_drain(use_rst ? "abort_rst" : "abort_clr");
        n_checks++;
        if (frame_cnt !== (use_rst ? 16'd1 : fc0 + 16'd1))
            $display("FAIL refeed_cnt: got %0d, need %0d", frame_cnt, use_rst ? 16'd1 : fc0 + 16'd1);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b1;
        en      = 1'b1;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0;
        m_ready = 1'b1;
        test_reset();
        test_ramp_frame();
        test_hop_frame();
        test_corners();
        test_backpressure();
        test_enable();
        test_abort(1'b1);
        test_abort(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
